// File: rtl/instrument_reg_arbiter.sv
// instrument_reg_arbiter
// Shares one AXI4-Lite master port between two register requesters.
// Requests are granted round-robin and exactly one AXI transaction is
// outstanding at any time. Each completed access is reported back to its
// requester with a one-cycle ack pulse, together with the response code and
// (for reads) the read data.
//
// Ports
//   ACLK, ARESET                  clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata   requester N command (held until reqN_ack)
//   reqN_ack/rdata/resp           requester N completion, data and response
//   M_AXI_*                       AXI4-Lite master (AW, W, B, AR, R channels)
module instrument_reg_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            req0_valid,
  input  logic                            req0_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req0_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   req0_wdata,
  output logic                            req0_ack,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   req0_rdata,
  output logic [1:0]                      req0_resp,
  input  logic                            req1_valid,
  input  logic                            req1_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req1_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   req1_wdata,
  output logic                            req1_ack,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   req1_rdata,
  output logic [1:0]                      req1_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic                          grant;       // requester owning the current access
  logic                          last_grant;  // requester served most recently
  logic                          win;         // arbitration result in IDLE
  logic                          win_write;
  logic                          any_valid;
  logic                          aw_done;
  logic                          w_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
  logic                          aw_valid;
  logic                          w_valid;
  logic                          ar_valid;
  logic                          b_ready;
  logic                          r_ready;
  logic                          unused_addr_bits;

  // Registers are word aligned; the two low address bits are not used.
  assign unused_addr_bits = ^{req0_addr[1:0], req1_addr[1:0]};

  assign any_valid = req0_valid | req1_valid;
  // A channel counts as done once its VALID has been retired or is being
  // accepted in this cycle.
  assign aw_done   = ~aw_valid | M_AXI_AWREADY;
  assign w_done    = ~w_valid  | M_AXI_WREADY;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = aw_valid;
  assign M_AXI_WVALID  = w_valid;
  assign M_AXI_ARVALID = ar_valid;
  assign M_AXI_BREADY  = b_ready;
  assign M_AXI_RREADY  = r_ready;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) begin
      win = ~last_grant;
    end else if (req1_valid) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    win_write = win ? req1_write : req0_write;
  end

  // Next-state logic of the access sequencer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (any_valid) begin
          next_state = win_write ? WR : RD_ADDR;
        end else begin
          next_state = IDLE;
        end
      end
      WR: begin
        if (aw_done && w_done) begin
          next_state = WR_RESP;
        end else begin
          next_state = WR;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          next_state = DONE;
        end else begin
          next_state = WR_RESP;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          next_state = RD_DATA;
        end else begin
          next_state = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          next_state = DONE;
        end else begin
          next_state = RD_DATA;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered AXI handshakes, command latch and requester completion outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      aw_valid   <= 1'b0;
      w_valid    <= 1'b0;
      ar_valid   <= 1'b0;
      b_ready    <= 1'b0;
      r_ready    <= 1'b0;
      req0_ack   <= 1'b0;
      req1_ack   <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      req0_resp  <= 2'b00;
      req1_resp  <= 2'b00;
    end else begin
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant      <= win;
            last_grant <= win;
            addr_q     <= win ? {req1_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00}
                              : {req0_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
            wdata_q    <= win ? req1_wdata : req0_wdata;
            aw_valid   <= win_write;
            w_valid    <= win_write;
            ar_valid   <= ~win_write;
          end
        end
        WR: begin
          // AW and W retire independently on their own handshakes.
          if (M_AXI_AWREADY) aw_valid <= 1'b0;
          if (M_AXI_WREADY)  w_valid  <= 1'b0;
          if (aw_done && w_done) b_ready <= 1'b1;
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            b_ready <= 1'b0;
            if (grant) begin
              req1_ack  <= 1'b1;
              req1_resp <= M_AXI_BRESP;
            end else begin
              req0_ack  <= 1'b1;
              req0_resp <= M_AXI_BRESP;
            end
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (M_AXI_RVALID) begin
            r_ready <= 1'b0;
            if (grant) begin
              req1_ack   <= 1'b1;
              req1_rdata <= M_AXI_RDATA;
              req1_resp  <= M_AXI_RRESP;
            end else begin
              req0_ack   <= 1'b1;
              req0_rdata <= M_AXI_RDATA;
              req0_resp  <= M_AXI_RRESP;
            end
          end
        end
        DONE: begin
        end
        default: begin
          aw_valid <= 1'b0;
          w_valid  <= 1'b0;
          ar_valid <= 1'b0;
          b_ready  <= 1'b0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instrument_reg_arbiter.sv
// Bench for instrument_reg_arbiter: directed requester commands against a
// small AXI4-Lite register slave model with configurable AWREADY delay, read
// stall and error responses. Expected completions go into a scoreboard queue
// and a negedge monitor pops one entry per ack.
module tb_instrument_reg_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [3:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_ack, req1_ack;
  logic [31:0] req0_rdata, req1_rdata;
  logic [1:0]  req0_resp, req1_resp;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  instrument_reg_arbiter #(.C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_rdata(req0_rdata),
    .req0_resp(req0_resp),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_rdata(req1_rdata),
    .req1_resp(req1_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- AXI4-Lite slave model ----------------
  logic [31:0] mem [4];
  int          aw_delay = 0;
  int          aw_wait;
  bit          r_stall = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic        got_aw, got_w;
  logic [3:0]  aw_addr_q;
  logic [31:0] wdata_q;
  int          cyc = 0;
  int          aw_cyc, w_cyc;
  logic        aw_hs, w_hs, ar_hs;

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid;
  assign arready = arvalid;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign ar_hs   = arvalid & arready;

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_wait <= 0;
      got_aw  <= 1'b0;
      got_w   <= 1'b0;
      bvalid  <= 1'b0;
      rvalid  <= 1'b0;
      bresp   <= 2'b00;
      rresp   <= 2'b00;
      rdata   <= 32'h0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      else aw_wait <= 0;
      if (aw_hs) aw_cyc <= cyc;
      if (w_hs)  w_cyc  <= cyc;
      if (bvalid && bready) bvalid <= 1'b0;
      if (rvalid && rready) rvalid <= 1'b0;
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        mem[aw_hs ? awaddr[3:2] : aw_addr_q[3:2]] <= w_hs ? wdata : wdata_q;
        bvalid <= 1'b1;
        bresp  <= bresp_cfg;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end else begin
        if (aw_hs) begin got_aw <= 1'b1; aw_addr_q <= awaddr; end
        if (w_hs)  begin got_w  <= 1'b1; wdata_q   <= wdata;  end
      end
      if (ar_hs && !r_stall) begin
        rvalid <= 1'b1;
        rdata  <= mem[araddr[3:2]];
        rresp  <= rresp_cfg;
      end
    end
  end

  // ---------------- VALID duration / address stability measurement ----------------
  bit         meas_en = 1'b0;
  int         aw_hi, w_hi;
  logic [3:0] aw_first;
  bit         addr_moved;

  always @(posedge ACLK) begin
    if (!meas_en) begin
      aw_hi <= 0; w_hi <= 0; addr_moved <= 1'b0;
    end else begin
      if (awvalid) begin
        aw_hi <= aw_hi + 1;
        if (aw_hi == 0) aw_first <= awaddr;
        else if (awaddr != aw_first) addr_moved <= 1'b1;
      end
      if (wvalid) w_hi <= w_hi + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          who;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input int who, input logic [31:0] rd, input logic [1:0] rs);
    exp_t e;
    e.who = who; e.rdata = rd; e.resp = rs;
    exp_q.push_back(e);
  endtask

  always @(negedge ACLK) begin : monitor
    exp_t e;
    if (!ARESET) begin
      if (req0_ack && req1_ack) begin
        checks++; errors++;
        $display("FAIL dual_ack: both acks high at cycle %0d, expected at most one", cyc);
      end else if (req0_ack || req1_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: ack%0d at cycle %0d, expected none", req1_ack ? 1 : 0, cyc);
        end else begin
          e = exp_q.pop_front();
          check("ack_requester", req1_ack ? 32'd1 : 32'd0, e.who);
          check("ack_rdata", req1_ack ? req1_rdata : req0_rdata, e.rdata);
          check("ack_resp", {30'd0, req1_ack ? req1_resp : req0_resp}, {30'd0, e.resp});
        end
      end
    end
  end

  // ---------------- requester driver ----------------
  // Raises valid, waits for the ack (bounded), drops valid in the ack cycle.
  // lat counts rising edges from raising valid to the ack being visible.
  task automatic run_req(input int n, input logic wr, input logic [3:0] addr,
                         input logic [31:0] data, output int lat);
    lat = 0;
    if (n == 0) begin
      req0_write = wr; req0_addr = addr; req0_wdata = data; req0_valid = 1'b1;
    end else begin
      req1_write = wr; req1_addr = addr; req1_wdata = data; req1_valid = 1'b1;
    end
    while (1) begin
      @(posedge ACLK); #1;
      lat++;
      if ((n == 0 && req0_ack) || (n == 1 && req1_ack)) break;
      if (lat >= 50) begin
        checks++; errors++;
        $display("FAIL ack_timeout: req%0d no ack after %0d cycles, expected ack", n, lat);
        break;
      end
    end
    if (n == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int lat, lat_b;
    ARESET = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 4'h0; req0_wdata = 32'h0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 4'h0; req1_wdata = 32'h0;
    repeat (3) @(posedge ACLK);
    #1;
    check("reset_handshakes", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    check("reset_acks", {30'd0, req0_ack, req1_ack}, 32'd0);
    check("reset_rdata0", req0_rdata, 32'd0);
    check("reset_rdata1", req1_rdata, 32'd0);
    check("reset_resp", {28'd0, req0_resp, req1_resp}, 32'd0);
    check("prot_strb", {21'd0, awprot, arprot, wstrb}, {21'd0, 3'b000, 3'b000, 4'hF});
    ARESET = 1'b0;

    // Single write with zero-wait slave: ack visible 3 edges after valid is
    // raised (grant, address/data, response, ack in DONE = 4th cycle).
    push(0, 32'h0, 2'b00);
    run_req(0, 1'b1, 4'h4, 32'h0000_0002, lat);
    check("write_latency", lat, 32'd3);
    check("aw_w_same_cycle", aw_cyc, w_cyc);

    // Fill the four registers through req0, then read them back through req1.
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h0, 2'b00);
      run_req(0, 1'b1, 4'(i * 4), 32'(i + 1), lat);
    end
    for (int i = 0; i < 4; i++) begin
      push(1, 32'(i + 1), 2'b00);
      run_req(1, 1'b0, 4'(i * 4), 32'h0, lat);
    end

    // Tie arbitration: last served was req1, so the order is 0,1,0,1.
    push(0, 32'h0, 2'b00);
    push(1, 32'd3, 2'b00);
    push(0, 32'h0, 2'b00);
    push(1, 32'd4, 2'b00);
    fork
      begin
        run_req(0, 1'b1, 4'h0, 32'h0000_00A5, lat);
        run_req(0, 1'b1, 4'h4, 32'h0000_005A, lat);
      end
      begin
        run_req(1, 1'b0, 4'h8, 32'h0, lat_b);
        run_req(1, 1'b0, 4'hC, 32'h0, lat_b);
      end
    join

    // Error responses are passed through untouched; a write leaves rdata as is.
    bresp_cfg = 2'b10;
    push(1, 32'd4, 2'b10);
    run_req(1, 1'b1, 4'hC, 32'h0000_0099, lat);
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b11;
    push(0, 32'h0000_00A5, 2'b11);
    run_req(0, 1'b0, 4'h0, 32'h0, lat);
    rresp_cfg = 2'b00;

    // Delayed AWREADY: W retires after one cycle, AW is held 4 cycles.
    aw_delay = 3;
    meas_en  = 1'b1;
    push(0, 32'h0000_00A5, 2'b00);
    run_req(0, 1'b1, 4'h8, 32'h0000_0077, lat);
    check("aw_valid_cycles", aw_hi, 32'd4);
    check("w_valid_cycles", w_hi, 32'd1);
    check("aw_addr_stable", {31'd0, addr_moved}, 32'd0);
    meas_en  = 1'b0;
    aw_delay = 0;

    // Reset while waiting for read data.
    r_stall = 1'b1;
    req1_write = 1'b0; req1_addr = 4'h4; req1_valid = 1'b1;
    lat = 0;
    while (!rready && lat < 20) begin
      @(posedge ACLK); #1;
      lat++;
    end
    check("reached_rd_data", {31'd0, rready}, 32'd1);
    ARESET = 1'b1;
    req1_valid = 1'b0;
    @(posedge ACLK); #1;
    check("abort_handshakes", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    check("abort_acks", {30'd0, req0_ack, req1_ack}, 32'd0);
    check("abort_rdata0", req0_rdata, 32'd0);
    check("abort_resp", {28'd0, req0_resp, req1_resp}, 32'd0);
    r_stall = 1'b0;
    ARESET  = 1'b0;

    // Post-reset tie goes to requester 0.
    push(0, 32'h0000_0077, 2'b00);
    push(1, 32'h0000_005A, 2'b00);
    fork
      run_req(0, 1'b0, 4'h8, 32'h0, lat);
      run_req(1, 1'b0, 4'h4, 32'h0, lat_b);
    join

    repeat (5) @(posedge ACLK);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
